ham_secded_decoder: RTL and testbench

Parametrised, pipelined Hamming SEC-DED decoder with a valid/ready stream interface. Accepts one extended-Hamming codeword per cycle, computes syndrome and overall parity, corrects single-bit errors, and flags double-bit errors. Keeps saturating statistics counters. Sits between the channel/receive path and the data consumer. Successor to the fixed 7-bit, purely combinational decoder.

---
 rtl/ham_pkg.sv | 43 ++++
 rtl/ham_syndrome.sv | 25 ++
 rtl/ham_secded_decoder.sv | 163 ++++++++++++++++
 tb/tb_ham_secded_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared definitions for the extended-Hamming (SEC-DED) decoder family.
//   par_w(data_w)  : number of Hamming parity bits for data_w data bits
//   is_pow2(x)     : true when x is a power of two (parity-bit positions)
//   data_pos(idx)  : Hamming position of data bit idx (3, 5, 6, 7, 9, ...)
//   ham_status_e   : per-word decode result
package ham_pkg;

   typedef enum logic [1:0] {
      HAM_OK     = 2'b00,
      HAM_CORR   = 2'b01,
      HAM_UNCORR = 2'b10
   } ham_status_e;

   // Smallest r with 2^r >= data_w + r + 1. Scanned downwards so the last hit is the minimum.
   function automatic int par_w(input int data_w);
      int r;
      r = 0;
      for (int i = 30; i >= 1; i--) begin
         if ((1 << i) >= data_w + i + 1) r = i;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int x);
      return (x > 0) && ((x & (x - 1)) == 0);
   endfunction

   // Data bits fill the non-power-of-two positions in ascending order.
   function automatic int data_pos(input int idx);
      int pos;
      int n;
      pos = 0;
      n   = 0;
      for (int k = 1; k < idx + 40; k++) begin
         if (!is_pow2(k)) begin
            if (n == idx && pos == 0) pos = k;
            n++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/ham_syndrome.sv
// Combinational syndrome / overall-parity generator for an extended Hamming codeword.
//   cw_i       : codeword, bit 0 = overall parity, bit k>=1 = Hamming position k
//   syndrome_o : XOR of all positions k>=1 whose bit is set
//   parity_o   : XOR of every codeword bit (0 = even parity holds)
module ham_syndrome
   import ham_pkg::*;
#(
   parameter  int unsigned DATA_W = 4,
   localparam int unsigned PAR_W  = int'(par_w(int'(DATA_W))),
   localparam int unsigned CW     = DATA_W + PAR_W + 1
) (
   input  logic [CW-1:0]    cw_i,
   output logic [PAR_W-1:0] syndrome_o,
   output logic             parity_o
);

   always_comb begin
      syndrome_o = '0;
      for (int unsigned k = 1; k < CW; k++) begin
         if (cw_i[k]) syndrome_o = syndrome_o ^ PAR_W'(k);
      end
      parity_o = ^cw_i;
   end

endmodule

// File: rtl/ham_secded_decoder.sv
// Two-stage pipelined SEC-DED decoder with valid/ready handshakes and saturating statistics.
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   : input handshake; cw_i and correct_en_i sampled together
//   out_valid_o / out_ready_i : output handshake; data_o, syndrome_o, status_o
//   clr_cnt_i                 : synchronous clear of the statistics counters
//   corr_cnt_o, uncorr_cnt_o  : saturating counts of CORRECTED / UNCORRECTABLE words delivered
module ham_secded_decoder
   import ham_pkg::*;
#(
   parameter  int unsigned DATA_W = 4,
   parameter  int unsigned CNT_W  = 16,
   localparam int unsigned PAR_W  = int'(par_w(int'(DATA_W))),
   localparam int unsigned CW     = DATA_W + PAR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CW-1:0]     cw_i,
   input  logic              correct_en_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [PAR_W-1:0]  syndrome_o,
   output logic [1:0]        status_o,
   input  logic              clr_cnt_i,
   output logic [CNT_W-1:0]  corr_cnt_o,
   output logic [CNT_W-1:0]  uncorr_cnt_o
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   // Whole pipeline moves as one; a stalled output freezes both stages.
   logic en;
   assign en         = !out_valid_o || out_ready_i;
   assign in_ready_o = en;

   // Stage 0 -> 1: syndrome and parity of the incoming word
   logic [PAR_W-1:0] syn;
   logic             par;

   ham_syndrome #(
      .DATA_W(DATA_W)
   ) u_syndrome (
      .cw_i      (cw_i),
      .syndrome_o(syn),
      .parity_o  (par)
   );

   logic             s1_valid_q;
   logic [CW-1:0]    s1_cw_q;
   logic [PAR_W-1:0] s1_syn_q;
   logic             s1_par_q;
   logic             s1_ce_q;

   // Stage 1 decode
   ham_status_e       status_d;
   logic              flip;
   logic [CW-1:0]     cw_fix;
   logic [DATA_W-1:0] data_d;

   always_comb begin
      status_d = HAM_OK;
      flip     = 1'b0;
      if (s1_syn_q == '0) begin
         // Only the overall parity bit can be wrong; data is intact.
         status_d = s1_par_q ? HAM_CORR : HAM_OK;
      end else if (!s1_par_q || (s1_syn_q > PAR_W'(CW - 1))) begin
         // Even parity with a syndrome means two errors; an out-of-range
         // syndrome can only occur for shortened codes.
         status_d = HAM_UNCORR;
      end else begin
         status_d = HAM_CORR;
         flip     = s1_ce_q;
      end

      cw_fix = s1_cw_q;
      for (int unsigned k = 1; k < CW; k++) begin
         if (flip && (s1_syn_q == PAR_W'(k))) cw_fix[k] = ~cw_fix[k];
      end
   end

   for (genvar i = 0; i < DATA_W; i++) begin : g_data
      assign data_d[i] = cw_fix[data_pos(i)];
   end

   // Stage 2 output registers
   logic              out_valid_q;
   logic [DATA_W-1:0] data_q;
   logic [PAR_W-1:0]  syn_q;
   ham_status_e       status_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_cw_q     <= '0;
         s1_syn_q    <= '0;
         s1_par_q    <= 1'b0;
         s1_ce_q     <= 1'b0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         syn_q       <= '0;
         status_q    <= HAM_OK;
      end else if (en) begin
         s1_valid_q <= in_valid_i;
         if (in_valid_i) begin
            s1_cw_q  <= cw_i;
            s1_syn_q <= syn;
            s1_par_q <= par;
            s1_ce_q  <= correct_en_i;
         end
         out_valid_q <= s1_valid_q;
         // Keep the last delivered result on the outputs across bubbles.
         if (s1_valid_q) begin
            data_q   <= data_d;
            syn_q    <= s1_syn_q;
            status_q <= status_d;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign data_o      = data_q;
   assign syndrome_o  = syn_q;
   assign status_o    = status_q;

   // Statistics: counted at the output handshake, saturating, clear loads this cycle's increment
   logic             out_hs;
   logic             corr_inc;
   logic             uncorr_inc;
   logic [CNT_W-1:0] corr_q, corr_d;
   logic [CNT_W-1:0] uncorr_q, uncorr_d;

   assign out_hs     = out_valid_q && out_ready_i;
   assign corr_inc   = out_hs && (status_q == HAM_CORR);
   assign uncorr_inc = out_hs && (status_q == HAM_UNCORR);

   always_comb begin
      corr_d   = corr_q;
      uncorr_d = uncorr_q;
      if (clr_cnt_i) begin
         corr_d   = CNT_W'(corr_inc);
         uncorr_d = CNT_W'(uncorr_inc);
      end else begin
         if (corr_inc && (corr_q != CntMax))     corr_d   = corr_q + 1'b1;
         if (uncorr_inc && (uncorr_q != CntMax)) uncorr_d = uncorr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else begin
         corr_q   <= corr_d;
         uncorr_q <= uncorr_d;
      end
   end

   assign corr_cnt_o   = corr_q;
   assign uncorr_cnt_o = uncorr_q;

endmodule

// File: tb/tb_ham_secded_decoder.sv
// Bench for ham_secded_decoder (DATA_W=4). Two instances share the stimulus: one with 16-bit
// counters, one with 2-bit counters to exercise saturation.
module tb_ham_secded_decoder;

   typedef struct packed {
      logic [3:0] data;
      logic [2:0] syn;
      logic [1:0] st;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] cw;
   logic       ce;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] data;
   logic [2:0] syn;
   logic [1:0] st;
   logic       clr_cnt;
   logic [15:0] corr_cnt;
   logic [15:0] uncorr_cnt;

   logic       s_in_ready;
   logic       s_out_valid;
   logic [3:0] s_data;
   logic [2:0] s_syn;
   logic [1:0] s_st;
   logic [1:0] s_corr_cnt;
   logic [1:0] s_uncorr_cnt;

   ham_secded_decoder #(.DATA_W(4), .CNT_W(16)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .cw_i        (cw),
      .correct_en_i(ce),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .data_o      (data),
      .syndrome_o  (syn),
      .status_o    (st),
      .clr_cnt_i   (clr_cnt),
      .corr_cnt_o  (corr_cnt),
      .uncorr_cnt_o(uncorr_cnt)
   );

   ham_secded_decoder #(.DATA_W(4), .CNT_W(2)) u_sat (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (s_in_ready),
      .cw_i        (cw),
      .correct_en_i(ce),
      .out_valid_o (s_out_valid),
      .out_ready_i (out_ready),
      .data_o      (s_data),
      .syndrome_o  (s_syn),
      .status_o    (s_st),
      .clr_cnt_i   (clr_cnt),
      .corr_cnt_o  (s_corr_cnt),
      .uncorr_cnt_o(s_uncorr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total;
   int   passed;
   exp_t q[$];
   int   corr_m, uncorr_m, scorr_m, suncorr_m;
   logic stalled_prev;
   logic [3:0] prev_data;
   logic [2:0] prev_syn;
   logic [1:0] prev_st;
   logic last_in_hs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference decoder written straight from the code definition.
   function automatic exp_t model(input logic [7:0] c, input logic cen);
      int s;
      int p;
      int pos[4];
      logic [7:0] f;
      exp_t r;
      pos[0] = 3; pos[1] = 5; pos[2] = 6; pos[3] = 7;
      s = 0;
      p = 0;
      for (int k = 0; k < 8; k++) begin
         if (c[k]) begin
            p = p ^ 1;
            if (k > 0) s = s ^ k;
         end
      end
      f = c;
      if (s == 0 && p == 0) r.st = 2'b00;
      else if (p == 1) begin
         r.st = 2'b01;
         if (s != 0 && cen) f[s] = ~f[s];
      end else r.st = 2'b10;
      for (int i = 0; i < 4; i++) r.data[i] = f[pos[i]];
      r.syn = 3'(s);
      return r;
   endfunction

   function automatic int cnt_next(input int c, input int inc, input int clr, input int maxv);
      if (clr != 0) return inc;
      return (c + inc > maxv) ? maxv : c + inc;
   endfunction

   // One clock cycle: starts and ends just after a falling edge.
   task automatic step(input logic v, input logic [7:0] c, input logic cen, input logic ordy,
                       input logic clr, input exp_t e);
      logic out_hs;
      exp_t got;
      int ci, ui;
      in_valid  = v;
      cw        = c;
      ce        = cen;
      out_ready = ordy;
      clr_cnt   = clr;
      #1;
      if (stalled_prev) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_data", 32'(data), 32'(prev_data));
         chk("hold_syn", 32'(syn), 32'(prev_syn));
         chk("hold_status", 32'(st), 32'(prev_st));
      end
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      out_hs     = out_valid && out_ready;
      last_in_hs = in_valid && in_ready;
      ci = 0;
      ui = 0;
      if (out_hs) begin
         chk("spurious_out", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            got = q.pop_front();
            chk("data", 32'(data), 32'(got.data));
            chk("syndrome", 32'(syn), 32'(got.syn));
            chk("status", 32'(st), 32'(got.st));
            ci = (got.st == 2'b01) ? 1 : 0;
            ui = (got.st == 2'b10) ? 1 : 0;
         end
      end
      corr_m    = cnt_next(corr_m, ci, int'(clr), 65535);
      uncorr_m  = cnt_next(uncorr_m, ui, int'(clr), 65535);
      scorr_m   = cnt_next(scorr_m, ci, int'(clr), 3);
      suncorr_m = cnt_next(suncorr_m, ui, int'(clr), 3);
      stalled_prev = out_valid && !out_ready;
      prev_data    = data;
      prev_syn     = syn;
      prev_st      = st;
      if (last_in_hs) q.push_back(e);
      @(posedge clk);
      #1;
      chk("corr_cnt", 32'(corr_cnt), 32'(corr_m));
      chk("uncorr_cnt", 32'(uncorr_cnt), 32'(uncorr_m));
      chk("sat_corr_cnt", 32'(s_corr_cnt), 32'(scorr_m));
      chk("sat_uncorr_cnt", 32'(s_uncorr_cnt), 32'(suncorr_m));
      @(negedge clk);
   endtask

   localparam exp_t ExpAA   = '{data: 4'b1011, syn: 3'b000, st: 2'b00};
   localparam exp_t Exp8A   = '{data: 4'b1011, syn: 3'b101, st: 2'b01};
   localparam exp_t Exp8ARaw = '{data: 4'b1001, syn: 3'b101, st: 2'b01};
   localparam exp_t ExpCA   = '{data: 4'b1101, syn: 3'b011, st: 2'b10};
   localparam exp_t ExpAB   = '{data: 4'b1011, syn: 3'b000, st: 2'b01};

   initial begin
      int   accepted;
      int   budget;
      logic rv;
      logic [7:0] rc;
      logic rce;
      total = 0; passed = 0;
      corr_m = 0; uncorr_m = 0; scorr_m = 0; suncorr_m = 0;
      stalled_prev = 1'b0;
      prev_data = '0; prev_syn = '0; prev_st = '0;
      last_in_hs = 1'b0;
      rst = 1'b1; in_valid = 1'b0; cw = '0; ce = 1'b1; out_ready = 1'b1; clr_cnt = 1'b0;

      // Reset state
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_syn", 32'(syn), 32'd0);
      chk("rst_status", 32'(st), 32'd0);
      chk("rst_corr", 32'(corr_cnt), 32'd0);
      chk("rst_uncorr", 32'(uncorr_cnt), 32'd0);
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b0;

      // Directed words, including two-cycle latency of the first one
      step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, ExpAA);
      chk("lat_edge1", 32'(out_valid), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, '0);
      chk("lat_edge2", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(data), 32'b1011);
      step(1'b1, 8'h8A, 1'b1, 1'b1, 1'b0, Exp8A);
      step(1'b1, 8'h8A, 1'b0, 1'b1, 1'b0, Exp8ARaw);
      step(1'b1, 8'hCA, 1'b1, 1'b1, 1'b0, ExpCA);
      step(1'b1, 8'hAB, 1'b1, 1'b1, 1'b0, ExpAB);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, '0);
      chk("directed_drained", 32'(q.size()), 32'd0);
      chk("directed_corr", 32'(corr_cnt), 32'd3);
      chk("directed_uncorr", 32'(uncorr_cnt), 32'd1);

      // Random stream with back-pressure
      accepted = 0;
      budget   = 0;
      while (accepted < 20 && budget < 300) begin
         rv  = ($urandom_range(0, 3) != 0);
         rc  = 8'($urandom);
         rce = 1'($urandom_range(0, 1));
         step(rv, rc, rce, 1'($urandom_range(0, 1)), 1'b0, model(rc, rce));
         if (last_in_hs) accepted++;
         budget++;
      end
      chk("random_accepted", 32'(accepted), 32'd20);
      budget = 0;
      while ((q.size() > 0 || out_valid) && budget < 20) begin
         step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, '0);
         budget++;
      end
      chk("random_drained", 32'(q.size()), 32'd0);

      // Saturation of the 2-bit counters
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, '0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'hAB, 1'b1, 1'b1, 1'b0, ExpAB);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, '0);
      chk("sat_corr_at_max", 32'(s_corr_cnt), 32'd3);
      chk("wide_corr_five", 32'(corr_cnt), 32'd5);

      // Clear coinciding with a corrected handshake leaves a count of one
      step(1'b1, 8'hAB, 1'b1, 1'b1, 1'b0, ExpAB);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, '0);
      chk("clr_with_hs_sat", 32'(s_corr_cnt), 32'd1);
      chk("clr_with_hs_wide", 32'(corr_cnt), 32'd1);

      // Reset with two words in flight
      step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, ExpAA);
      step(1'b1, 8'hCA, 1'b1, 1'b1, 1'b0, ExpCA);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_corr", 32'(corr_cnt), 32'd0);
      chk("midrst_uncorr", 32'(uncorr_cnt), 32'd0);
      q.delete();
      corr_m = 0; uncorr_m = 0; scorr_m = 0; suncorr_m = 0;
      stalled_prev = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'h8A, 1'b1, 1'b1, 1'b0, Exp8A);
      chk("post_rst_edge1", 32'(out_valid), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, '0);
      chk("post_rst_edge2", 32'(out_valid), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, '0);
      chk("post_rst_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
